// File: rtl/half_adder.sv
// Half adder with a registered sum/carry path and a saturating counter
// of enabled carry events.
module half_adder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             A,
  input  logic             B,
  output logic             S,
  output logic             Co,
  input  logic             en,
  output logic             S_r,
  output logic             Co_r,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] carry_cnt,
  output logic             cnt_sat
);

  logic             w_s;
  logic             w_co;
  logic             w_sat;
  logic             r_s;
  logic             r_co;
  logic [CNT_W-1:0] r_cnt;

  // Combinational path depends only on A/B so X on en/cnt_clr cannot leak in.
  assign w_s   = A ^ B;
  assign w_co  = A & B;
  assign w_sat = &r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s  <= 1'b0;
      r_co <= 1'b0;
    end else if (en) begin
      r_s  <= w_s;
      r_co <= w_co;
    end
  end

  // Clear wins over increment; increment stops at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (cnt_clr)
      r_cnt <= '0;
    else if (en && w_co && !w_sat)
      r_cnt <= r_cnt + 1'b1;
  end

  assign S         = w_s;
  assign Co        = w_co;
  assign S_r       = r_s;
  assign Co_r      = r_co;
  assign carry_cnt = r_cnt;
  assign cnt_sat   = w_sat;

endmodule

// File: tb/tb_half_adder.sv
// Bench for half_adder: two instances (CNT_W=8 and CNT_W=2) share stimulus
// and are checked against an arithmetic reference model.
module tb_half_adder;

  logic       clk, rst_n, A, B, en, cnt_clr;
  logic       S8, Co8, Sr8, Cor8, sat8;
  logic       S2, Co2, Sr2, Cor2, sat2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_sr, m_cor, m_cnt8, m_cnt2;

  half_adder #(.CNT_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .S(S8), .Co(Co8), .en(en),
    .S_r(Sr8), .Co_r(Cor8), .cnt_clr(cnt_clr), .carry_cnt(cnt8), .cnt_sat(sat8)
  );

  half_adder #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .S(S2), .Co(Co2), .en(en),
    .S_r(Sr2), .Co_r(Cor2), .cnt_clr(cnt_clr), .carry_cnt(cnt2), .cnt_sat(sat2)
  );

  function automatic int sum_bit(input logic a, input logic b);
    return (int'(a) + int'(b)) % 2;
  endfunction

  function automatic int carry_bit(input logic a, input logic b);
    return (int'(a) + int'(b)) / 2;
  endfunction

  function automatic void model_edge();
    if (rst_n !== 1'b1) begin
      m_sr = 0; m_cor = 0; m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      if (cnt_clr === 1'b1) begin
        m_cnt8 = 0; m_cnt2 = 0;
      end else if (en === 1'b1 && carry_bit(A, B) == 1) begin
        m_cnt8 = (m_cnt8 + 1 > 255) ? 255 : m_cnt8 + 1;
        m_cnt2 = (m_cnt2 + 1 > 3) ? 3 : m_cnt2 + 1;
      end
      if (en === 1'b1) begin
        m_sr  = sum_bit(A, B);
        m_cor = carry_bit(A, B);
      end
    end
  endfunction

  // One clock cycle; outputs are stable 1 ns after the falling edge.
  task automatic tick();
    #2 clk = 1'b1;
    model_edge();
    #3 clk = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; cnt_clr = 1'b0; A = 1'b1; B = 1'b1; clk = 1'b0;
    m_sr = 0; m_cor = 0; m_cnt8 = 0; m_cnt2 = 0;
    #3;
    checks++;
    if ({Sr8, Cor8, cnt8, sat8, Sr2, Cor2, cnt2, sat2} !== '0) begin
      errors++;
      $display("FAIL reset_state got Sr=%b Cor=%b cnt8=%0d sat8=%b cnt2=%0d sat2=%b need all 0",
               Sr8, Cor8, cnt8, sat8, cnt2, sat2);
    end
    tick();
    checks++;
    if ({Sr8, Cor8, cnt8, cnt2} !== '0 || S8 !== 1'b0 || Co8 !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold got Sr=%b Cor=%b cnt8=%0d S=%b Co=%b need 0 0 0 0 1",
               Sr8, Cor8, cnt8, S8, Co8);
    end
    rst_n = 1'b1; en = 1'b0;
    #2;
  endtask

  task automatic test_comb();
    logic [1:0] pat [4];
    pat[0] = 2'b00; pat[1] = 2'b01; pat[2] = 2'b10; pat[3] = 2'b11;
    for (int i = 0; i < 4; i++) begin
      A = pat[i][0]; B = pat[i][1];
      #2;
      checks++;
      if (S8 !== 1'(sum_bit(A, B)) || Co8 !== 1'(carry_bit(A, B)) ||
          S2 !== 1'(sum_bit(A, B)) || Co2 !== 1'(carry_bit(A, B))) begin
        errors++;
        $display("FAIL comb_truth A=%b B=%b got S=%b Co=%b need S=%0d Co=%0d",
                 A, B, S8, Co8, sum_bit(A, B), carry_bit(A, B));
      end
    end
    // unknown control inputs must not disturb the combinational path
    en = 1'bx; cnt_clr = 1'bz; A = 1'b1; B = 1'b0;
    #1;
    checks++;
    if (S8 !== 1'b1 || Co8 !== 1'b0) begin
      errors++;
      $display("FAIL comb_x_ctrl got S=%b Co=%b need 1 0", S8, Co8);
    end
    en = 1'b0; cnt_clr = 1'b0;
    #1;
  endtask

  task automatic test_capture();
    en = 1'b1; A = 1'b1; B = 1'b1;
    tick();
    checks++;
    if (Sr8 !== 1'b0 || Cor8 !== 1'b1 || cnt8 !== 8'd1 || cnt2 !== 2'd1) begin
      errors++;
      $display("FAIL capture got Sr=%b Cor=%b cnt8=%0d cnt2=%0d need 0 1 1 1",
               Sr8, Cor8, cnt8, cnt2);
    end
  endtask

  task automatic test_hold();
    en = 1'b0; A = 1'b1; B = 1'b0;
    tick();
    checks++;
    if (Sr8 !== 1'b0 || Cor8 !== 1'b1 || cnt8 !== 8'd1 || S8 !== 1'b1 || Co8 !== 1'b0) begin
      errors++;
      $display("FAIL hold got Sr=%b Cor=%b cnt8=%0d S=%b Co=%b need 0 1 1 1 0",
               Sr8, Cor8, cnt8, S8, Co8);
    end
    A = 1'b1; B = 1'b1;
    tick();
    checks++;
    if (cnt8 !== 8'd1 || Cor8 !== 1'b1 || Co8 !== 1'b1) begin
      errors++;
      $display("FAIL hold_carry got cnt8=%0d Cor=%b Co=%b need 1 1 1", cnt8, Cor8, Co8);
    end
  endtask

  task automatic test_clear();
    en = 1'b1; A = 1'b1; B = 1'b1; cnt_clr = 1'b1;
    tick();
    checks++;
    if (cnt8 !== 8'd0 || cnt2 !== 2'd0 || Cor8 !== 1'b1) begin
      errors++;
      $display("FAIL clear_priority got cnt8=%0d cnt2=%0d Cor=%b need 0 0 1", cnt8, cnt2, Cor8);
    end
    cnt_clr = 1'b0;
  endtask

  task automatic test_saturate();
    int exp2 [5];
    exp2 = '{1, 2, 3, 3, 3};
    en = 1'b1; A = 1'b1; B = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (cnt2 !== 2'(exp2[i]) || sat2 !== (i >= 2) || cnt8 !== 8'(i + 1) || sat8 !== 1'b0) begin
        errors++;
        $display("FAIL saturate edge=%0d got cnt2=%0d sat2=%b cnt8=%0d need %0d %0d %0d",
                 i + 1, cnt2, sat2, cnt8, exp2[i], (i >= 2), i + 1);
      end
    end
  endtask

  task automatic test_reset_midcount();
    #1 rst_n = 1'b0;
    model_edge();
    A = 1'b0; B = 1'b1;
    #1;
    checks++;
    if (cnt2 !== 2'd0 || sat2 !== 1'b0 || cnt8 !== 8'd0 || Sr8 !== 1'b0 || Cor8 !== 1'b0 ||
        S8 !== 1'b1 || Co8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_midcount got cnt2=%0d sat2=%b cnt8=%0d Sr=%b Cor=%b S=%b Co=%b need 0 0 0 0 0 1 0",
               cnt2, sat2, cnt8, Sr8, Cor8, S8, Co8);
    end
    en = 1'b1; cnt_clr = 1'b1; A = 1'b1; B = 1'b1;
    tick();
    checks++;
    if (cnt8 !== 8'd0 || Cor8 !== 1'b0 || Co8 !== 1'b1) begin
      errors++;
      $display("FAIL reset_ignores_ctrl got cnt8=%0d Cor=%b Co=%b need 0 0 1", cnt8, Cor8, Co8);
    end
    cnt_clr = 1'b0; en = 1'b0;
    #1 rst_n = 1'b1;
    tick();
    checks++;
    if (Cor8 !== 1'b0 || cnt8 !== 8'd0) begin
      errors++;
      $display("FAIL release_no_en got Cor=%b cnt8=%0d need 0 0", Cor8, cnt8);
    end
    en = 1'b1;
    tick();
    checks++;
    if (Cor8 !== 1'b1 || Sr8 !== 1'b0 || cnt8 !== 8'd1) begin
      errors++;
      $display("FAIL first_capture got Sr=%b Cor=%b cnt8=%0d need 0 1 1", Sr8, Cor8, cnt8);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      A = 1'($urandom); B = 1'($urandom);
      en = ($urandom_range(0, 3) != 0);
      cnt_clr = ($urandom_range(0, 19) == 0);
      #1;
      checks++;
      if (S8 !== 1'(sum_bit(A, B)) || Co8 !== 1'(carry_bit(A, B)) ||
          S2 !== 1'(sum_bit(A, B)) || Co2 !== 1'(carry_bit(A, B))) begin
        errors++;
        $display("FAIL rand_comb i=%0d A=%b B=%b got S=%b Co=%b", i, A, B, S8, Co8);
      end
      tick();
      checks++;
      if (Sr8 !== 1'(m_sr) || Cor8 !== 1'(m_cor) || Sr2 !== 1'(m_sr) || Cor2 !== 1'(m_cor) ||
          cnt8 !== 8'(m_cnt8) || cnt2 !== 2'(m_cnt2) ||
          sat8 !== (m_cnt8 == 255) || sat2 !== (m_cnt2 == 3)) begin
        errors++;
        $display("FAIL rand_reg i=%0d got Sr=%b Cor=%b cnt8=%0d cnt2=%0d sat2=%b need %0d %0d %0d %0d %0d",
                 i, Sr8, Cor8, cnt8, cnt2, sat2, m_sr, m_cor, m_cnt8, m_cnt2, (m_cnt2 == 3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_comb();
    test_capture();
    test_hold();
    test_clear();
    test_saturate();
    test_reset_midcount();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
